decoder_nto2n_seq: RTL and testbench

//  Parametrised, registered N-to-2^N one-hot decoder; successor to the fixed 3x8 combinational decoder.
//  Two modes: DIRECT registers the decode of an external select; SCAN steps an internal index through all outputs at a programmable rate.

---
 rtl/decoder_pkg.sv | 24 ++
 rtl/decoder_tick_gen.sv | 28 ++
 rtl/decoder_nto2n_seq.sv | 109 ++++++++++
 tb/tb_decoder_nto2n_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered N-to-2^N decoder.
// The onehot helper decodes up to DEC_MAX_N select bits; callers truncate to their width.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int DEC_MAX_N = 8;
    localparam int DEC_MAX_W = 2 ** DEC_MAX_N;

    function automatic logic [DEC_MAX_W-1:0] onehot(input logic [DEC_MAX_N-1:0] idx);
        logic [DEC_MAX_W-1:0] d;
        d      = '0;
        d[idx] = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/decoder_tick_gen.sv
// Scan-rate prescaler: counts 0..DIV-1 while run is high and flags the terminal count.
// With DIV=1 the counter is a constant zero, so tick simply follows run.
module decoder_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);

    logic [PW-1:0] pre_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre_reg <= '0;
        end else if (run) begin
            pre_reg <= (pre_reg == TERM) ? '0 : pre_reg + 1'b1;
        end
    end

    assign tick = run && (pre_reg == TERM);

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N decoder with a DIRECT select path and a self-stepping SCAN mode.
// Outputs are computed from the state being entered, so every change is visible right after its edge.
module decoder_nto2n_seq
    import decoder_pkg::*;
#(
    parameter int N          = 3,
    parameter int SCAN_DIV   = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     sel,
    input  logic             load,
    output logic [2**N-1:0]  out,
    output logic [N-1:0]     idx,
    output logic             valid,
    output logic             wrap
);

    localparam int W = 2 ** N;
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [N-1:0] IDX_MAX = '1;

    state_t         state_reg, state_next;
    logic [N-1:0]   idx_reg, idx_next;
    logic [W-1:0]   out_reg, out_next;
    logic           valid_reg, valid_next;
    logic           wrap_reg, wrap_next;
    logic [W-1:0]   dec;
    logic           scan_entry, scan_run, tick_clr, tick;

    always_comb begin
        state_next = IDLE;
        if (en) begin
            state_next = (mode == MODE_SCAN) ? SCAN : DIRECT;
        end
    end

    // The prescaler only advances across consecutive SCAN cycles; entry or load restarts the dwell.
    assign scan_entry = (state_next == SCAN) && (state_reg != SCAN);
    assign scan_run   = (state_next == SCAN) && (state_reg == SCAN);
    assign tick_clr   = scan_entry || ((state_next == SCAN) && load);

    decoder_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .run  (scan_run),
        .tick (tick)
    );

    always_comb begin
        idx_next   = idx_reg;
        valid_next = 1'b0;
        wrap_next  = 1'b0;
        case (state_next)
            DIRECT: begin
                idx_next   = sel;
                valid_next = 1'b1;
            end
            SCAN: begin
                valid_next = 1'b1;
                if (load) begin
                    idx_next = sel;
                end else if (tick) begin
                    idx_next  = idx_reg + 1'b1;
                    wrap_next = (idx_reg == IDX_MAX);
                end
            end
            default: ;
        endcase
    end

    assign dec = W'(onehot(DEC_MAX_N'(idx_next)));

    // Polarity is folded in before the register so out never glitches between polarities.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_out_bit
            assign out_next[gi] = valid_next ? (dec[gi] ^ POL) : POL;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            out_reg   <= {W{POL}};
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            out_reg   <= out_next;
            valid_reg <= valid_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign out   = out_reg;
    assign idx   = idx_reg;
    assign valid = valid_reg;
    assign wrap  = wrap_reg;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Scoreboard bench: stimulus queues the expected post-edge outputs, a negedge monitor checks them.
// Instance a: N=3, SCAN_DIV=4, active-high. Instance b: N=2, SCAN_DIV=1, active-low.
module tb_decoder_nto2n_seq;

    typedef struct {
        int         cyc;
        bit         inst;
        logic [7:0] out;
        logic [2:0] idx;
        logic       valid;
        logic       wrap;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_a = 1'b0, mode_a = 1'b0, load_a = 1'b0;
    logic [2:0] sel_a = 3'd0;
    logic [7:0] out_a;
    logic [2:0] idx_a;
    logic       valid_a, wrap_a;
    logic       en_b = 1'b0, mode_b = 1'b0, load_b = 1'b0;
    logic [1:0] sel_b = 2'd0;
    logic [3:0] out_b;
    logic [1:0] idx_b;
    logic       valid_b, wrap_b;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t mon_e;

    logic [7:0] dtbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [3:0] btbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    decoder_nto2n_seq #(.N(3), .SCAN_DIV(4), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .sel(sel_a), .load(load_a),
        .out(out_a), .idx(idx_a), .valid(valid_a), .wrap(wrap_a)
    );

    decoder_nto2n_seq #(.N(2), .SCAN_DIV(1), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .sel(sel_b), .load(load_b),
        .out(out_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_a(input logic [7:0] o, input logic [2:0] i, input logic v,
                            input logic w, input string nm);
        exp_t e;
        e.cyc = cyc + 1; e.inst = 1'b0; e.out = o; e.idx = i;
        e.valid = v; e.wrap = w; e.name = nm;
        q.push_back(e);
    endtask

    task automatic expect_b(input logic [3:0] o, input logic [1:0] i, input logic v,
                            input logic w, input string nm);
        exp_t e;
        e.cyc = cyc + 1; e.inst = 1'b1; e.out = {4'h0, o}; e.idx = {1'b0, i};
        e.valid = v; e.wrap = w; e.name = nm;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            logic [7:0] ao;
            logic [2:0] ai;
            logic       av, aw;
            mon_e = q.pop_front();
            if (mon_e.inst) begin
                ao = {4'h0, out_b}; ai = {1'b0, idx_b}; av = valid_b; aw = wrap_b;
            end else begin
                ao = out_a; ai = idx_a; av = valid_a; aw = wrap_a;
            end
            checks++;
            if (mon_e.cyc != cyc || ao !== mon_e.out || ai !== mon_e.idx ||
                av !== mon_e.valid || aw !== mon_e.wrap) begin
                failures++;
                $display("FAIL %s cyc=%0d/%0d out=%h/%h idx=%0d/%0d valid=%b/%b wrap=%b/%b (actual/required)",
                         mon_e.name, cyc, mon_e.cyc, ao, mon_e.out, ai, mon_e.idx,
                         av, mon_e.valid, aw, mon_e.wrap);
            end else begin
                $display("ok   %s cyc=%0d out=%h idx=%0d valid=%b wrap=%b",
                         mon_e.name, cyc, ao, ai, av, aw);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before stimulus completed");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int waitc;
        // Reset held two cycles, then idle with en=0.
        rst = 1'b1;
        repeat (2) begin
            expect_a(8'h00, 3'd0, 1'b0, 1'b0, "rst_a");
            expect_b(4'hF, 2'd0, 1'b0, 1'b0, "rst_b");
            step();
        end
        rst = 1'b0;
        expect_a(8'h00, 3'd0, 1'b0, 1'b0, "idle_a");
        expect_b(4'hF, 2'd0, 1'b0, 1'b0, "idle_b");
        step();

        // DIRECT: new select every cycle, one-cycle latency.
        en_a = 1'b1; mode_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel_a = 3'(i);
            expect_a(dtbl[i], 3'(i), 1'b1, 1'b0, "direct");
            step();
        end
        sel_a = 3'd3; load_a = 1'b1;
        expect_a(8'h08, 3'd3, 1'b1, 1'b0, "direct_load_ignored");
        step();
        load_a = 1'b0; sel_a = 3'd0;
        expect_a(8'h01, 3'd0, 1'b1, 1'b0, "direct_idx0");
        step();

        // SCAN from idx 0: 4-cycle dwell, wrap after the full 32-cycle sweep.
        mode_a = 1'b1;
        for (int j = 0; j < 36; j++) begin
            expect_a(dtbl[(j / 4) % 8], 3'((j / 4) % 8), 1'b1, (j == 32), "scan");
            step();
        end

        // Load coinciding with a terminal count wins and restarts the dwell.
        load_a = 1'b1; sel_a = 3'd6;
        expect_a(8'h40, 3'd6, 1'b1, 1'b0, "load_tc");
        step();
        load_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_a(8'h40, 3'd6, 1'b1, 1'b0, "load_dwell");
            step();
        end
        expect_a(8'h80, 3'd7, 1'b1, 1'b0, "load_step");
        step();

        // Load of 0 while at the top index must not wrap.
        load_a = 1'b1; sel_a = 3'd0;
        expect_a(8'h01, 3'd0, 1'b1, 1'b0, "load_nowrap");
        step();
        load_a = 1'b0;
        expect_a(8'h01, 3'd0, 1'b1, 1'b0, "load_nowrap_hold");
        step();

        // Park at idx 5 and reset mid-dwell.
        load_a = 1'b1; sel_a = 3'd5;
        expect_a(8'h20, 3'd5, 1'b1, 1'b0, "load5");
        step();
        load_a = 1'b0;
        expect_a(8'h20, 3'd5, 1'b1, 1'b0, "load5_hold");
        step();
        rst = 1'b1;
        expect_a(8'h00, 3'd0, 1'b0, 1'b0, "rst_mid");
        step();
        rst = 1'b0;
        expect_a(8'h01, 3'd0, 1'b1, 1'b0, "restart");
        step();
        for (int k = 0; k < 3; k++) begin
            expect_a(8'h01, 3'd0, 1'b1, 1'b0, "restart_dwell");
            step();
        end
        expect_a(8'h02, 3'd1, 1'b1, 1'b0, "restart_step");
        step();

        // en drop forces idle with idx held; re-entry resumes decoding idx.
        en_a = 1'b0;
        expect_a(8'h00, 3'd1, 1'b0, 1'b0, "en_off");
        step();
        en_a = 1'b1;
        expect_a(8'h02, 3'd1, 1'b1, 1'b0, "scan_reentry");
        step();
        en_a = 1'b0;

        // Active-low, N=2, SCAN_DIV=1: steps every cycle, wraps every 4th.
        en_b = 1'b1; mode_b = 1'b1;
        for (int j = 0; j < 10; j++) begin
            expect_b(btbl[j % 4], 2'(j % 4), 1'b1, (j > 0 && (j % 4) == 0), "b_scan");
            step();
        end
        en_b = 1'b0;
        expect_b(4'hF, 2'd1, 1'b0, 1'b0, "b_idle");
        step();

        waitc = 0;
        while (q.size() > 0 && waitc < 10) begin
            step();
            waitc++;
        end
        if (q.size() > 0) begin
            $display("FAIL drain pending=%0d required=0", q.size());
            failures++;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
